// File: rtl/steer_target_ctrl.sv
// Closed-loop steering controller: drives one wheel's rotation motor toward a
// latched target angle using shortest-path results from the delta calculator.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | one-cycle request to the delta calculator
// WAIT  | waiting for calc_updated, bounded by CALC_TIMEOUT
// EVAL  | apply ramp / slow-zone / reversal rules to the latest result
// DONE  | one-cycle completion pulse
// FAULT | sticky error, motor stopped until abort
module steer_target_ctrl #(
  parameter logic [11:0] TOLERANCE    = 12'd8,
  parameter int unsigned SETTLE_COUNT = 3,
  parameter logic [11:0] SLOW_ZONE    = 12'd256,
  parameter logic [7:0]  MAX_DUTY     = 8'd255,
  parameter logic [7:0]  MIN_DUTY     = 8'd32,
  parameter logic [7:0]  RAMP_STEP    = 8'd4,
  parameter logic [4:0]  CALC_TIMEOUT = 5'd16,
  parameter logic [15:0] MAX_ITER     = 16'd4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [11:0] target_angle,
  output logic [11:0] calc_target,
  output logic        enable_calc,
  input  logic        dir_shortest,
  input  logic [11:0] delta_angle,
  input  logic        calc_updated,
  output logic        pwm_enable,
  output logic        pwm_dir,
  output logic [7:0]  pwm_duty,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] EVAL  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] FAULT = 3'd5;

  logic [2:0]  state;
  logic [4:0]  wait_cnt;
  logic [7:0]  settle_cnt;
  logic [15:0] iter_cnt;
  logic        dir_reg;
  logic [11:0] delta_reg;

  logic        on_target;
  logic        reversing;
  logic [7:0]  cap;
  logic [8:0]  sum9;
  logic [7:0]  ramp_duty;
  logic [7:0]  settle_next;
  logic [15:0] iter_next;

  always_comb begin
    on_target   = (delta_reg <= TOLERANCE);
    cap         = (delta_reg < SLOW_ZONE) ? MIN_DUTY : MAX_DUTY;
    reversing   = (dir_reg != pwm_dir) && (pwm_duty != 8'd0);
    sum9        = {1'b0, pwm_duty} + {1'b0, RAMP_STEP};
    settle_next = settle_cnt + 8'd1;
    iter_next   = iter_cnt + 16'd1;
    // Already above the cap (e.g. entering the slow zone) drops straight to it.
    if (pwm_duty >= cap || sum9 > {1'b0, cap})
      ramp_duty = cap;
    else
      ramp_duty = sum9[7:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      calc_target <= 12'd0;
      pwm_dir     <= 1'b0;
      pwm_duty    <= 8'd0;
      wait_cnt    <= 5'd0;
      settle_cnt  <= 8'd0;
      iter_cnt    <= 16'd0;
      dir_reg     <= 1'b0;
      delta_reg   <= 12'd0;
    end else if (abort) begin
      state    <= IDLE;
      pwm_duty <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            calc_target <= target_angle;
            pwm_duty    <= 8'd0;
            settle_cnt  <= 8'd0;
            iter_cnt    <= 16'd0;
            state       <= REQ;
          end
        end
        REQ: begin
          wait_cnt <= 5'd0;
          state    <= WAIT;
        end
        WAIT: begin
          if (calc_updated) begin
            dir_reg   <= dir_shortest;
            delta_reg <= delta_angle;
            state     <= EVAL;
          end else if (wait_cnt == CALC_TIMEOUT - 5'd1) begin
            pwm_duty <= 8'd0;
            state    <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + 5'd1;
          end
        end
        EVAL: begin
          iter_cnt <= iter_next;
          if (on_target) begin
            pwm_duty   <= 8'd0;
            settle_cnt <= settle_next;
            if (settle_next == SETTLE_COUNT[7:0])
              state <= DONE;
            else if (iter_next == MAX_ITER)
              state <= FAULT;
            else
              state <= REQ;
          end else begin
            settle_cnt <= 8'd0;
            if (iter_next == MAX_ITER) begin
              pwm_duty <= 8'd0;
              state    <= FAULT;
            end else begin
              // The motor must come to rest before the direction flips.
              if (reversing) begin
                pwm_duty <= 8'd0;
              end else begin
                pwm_dir  <= dir_reg;
                pwm_duty <= ramp_duty;
              end
              state <= REQ;
            end
          end
        end
        DONE: begin
          pwm_duty <= 8'd0;
          state    <= IDLE;
        end
        FAULT: begin
          pwm_duty <= 8'd0;
        end
        default: begin
          pwm_duty <= 8'd0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign enable_calc = (state == REQ);
  assign done        = (state == DONE);
  assign fault       = (state == FAULT);
  assign busy        = (state == REQ) || (state == WAIT) || (state == EVAL);
  assign pwm_enable  = busy && (pwm_duty != 8'd0);

endmodule

// File: tb/tb_steer_target_ctrl.sv
// Bench for steer_target_ctrl: a calculator stub answers each request 6 cycles
// later with directed deltas, and outputs are compared against hand-computed values.
module tb_steer_target_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] target_angle = 12'd0;
  logic [11:0] calc_target;
  logic        enable_calc;
  logic        dir_shortest = 1'b0;
  logic [11:0] delta_angle = 12'd0;
  logic        calc_updated = 1'b0;
  logic        pwm_enable;
  logic        pwm_dir;
  logic [7:0]  pwm_duty;
  logic        busy;
  logic        done;
  logic        fault;

  int n_total = 0;
  int n_pass  = 0;

  steer_target_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .target_angle(target_angle), .calc_target(calc_target),
    .enable_calc(enable_calc), .dir_shortest(dir_shortest),
    .delta_angle(delta_angle), .calc_updated(calc_updated),
    .pwm_enable(pwm_enable), .pwm_dir(pwm_dir), .pwm_duty(pwm_duty),
    .busy(busy), .done(done), .fault(fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] delta;
    logic        dir;
    int          duty;
    int          pdir;
    int          en;
    int          bsy;
    int          dn;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (enable_calc) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!ok) chk("req_timeout", 0, 1);
  endtask

  // Answer the next request 6 cycles later; return at the cycle the new pwm values show.
  task automatic do_eval(input logic [11:0] d, input logic dr, output bit ok);
    wait_req(ok);
    if (ok) begin
      repeat (6) @(negedge clock);
      delta_angle  = d;
      dir_shortest = dr;
      calc_updated = 1'b1;
      @(negedge clock);
      calc_updated = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic start_move(input logic [11:0] tgt);
    target_angle = tgt;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("start_enable_calc", int'(enable_calc), 1);
    chk("start_calc_target", int'(calc_target), int'(tgt));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_duty"}, int'(pwm_duty), 0);
    chk({tag, "_dir"}, int'(pwm_dir), 0);
    chk({tag, "_pwm_enable"}, int'(pwm_enable), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_fault"}, int'(fault), 0);
    chk({tag, "_enable_calc"}, int'(enable_calc), 0);
    chk({tag, "_calc_target"}, int'(calc_target), 0);
  endtask

  initial begin
    bit ok;
    int exp_duty;

    //           delta   dir  duty pdir en bsy dn
    vecs[0]  = '{12'd200,  1'b0, 32,  0, 1, 1, 0};
    vecs[1]  = '{12'd255,  1'b0, 32,  0, 1, 1, 0};
    vecs[2]  = '{12'd256,  1'b0, 36,  0, 1, 1, 0};
    vecs[3]  = '{12'd1000, 1'b0, 40,  0, 1, 1, 0};
    vecs[4]  = '{12'd500,  1'b1, 0,   0, 0, 1, 0};
    vecs[5]  = '{12'd500,  1'b1, 4,   1, 1, 1, 0};
    vecs[6]  = '{12'd5,    1'b1, 0,   1, 0, 1, 0};
    vecs[7]  = '{12'd9,    1'b1, 4,   1, 1, 1, 0};
    vecs[8]  = '{12'd8,    1'b1, 0,   1, 0, 1, 0};
    vecs[9]  = '{12'd5,    1'b1, 0,   1, 0, 1, 0};
    vecs[10] = '{12'd5,    1'b1, 0,   1, 0, 0, 1};

    repeat (2) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    // Ramp-up to saturation, then a silent calculator forces a timeout.
    start_move(12'd100);
    for (int i = 1; i <= 64; i++) begin
      do_eval(12'd1000, 1'b0, ok);
      exp_duty = (4 * i > 255) ? 255 : 4 * i;
      chk($sformatf("ramp_duty_%0d", i), int'(pwm_duty), exp_duty);
      chk("ramp_dir", int'(pwm_dir), 0);
      chk("ramp_busy", int'(busy), 1);
    end
    wait_req(ok);
    repeat (16) @(negedge clock);
    chk("wait16_fault", int'(fault), 0);
    chk("wait16_pwm_enable", int'(pwm_enable), 1);
    @(negedge clock);
    chk("timeout_fault", int'(fault), 1);
    chk("timeout_duty", int'(pwm_duty), 0);
    chk("timeout_busy", int'(busy), 0);
    target_angle = 12'd7;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk("fault_start_ignored", int'(fault), 1);
    chk("fault_no_req", int'(enable_calc), 0);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_clears_fault", int'(fault), 0);
    chk("abort_idle_busy", int'(busy), 0);
    @(negedge clock);

    // Slow zone, reversal and settling from duty 100.
    start_move(12'd3000);
    for (int i = 1; i <= 25; i++) do_eval(12'd1000, 1'b0, ok);
    chk("pre_table_duty", int'(pwm_duty), 100);
    for (int i = 0; i < 11; i++) begin
      do_eval(vecs[i].delta, vecs[i].dir, ok);
      chk($sformatf("v%0d_duty", i), int'(pwm_duty), vecs[i].duty);
      chk($sformatf("v%0d_dir", i), int'(pwm_dir), vecs[i].pdir);
      chk($sformatf("v%0d_pwm_enable", i), int'(pwm_enable), vecs[i].en);
      chk($sformatf("v%0d_busy", i), int'(busy), vecs[i].bsy);
      chk($sformatf("v%0d_done", i), int'(done), vecs[i].dn);
      chk($sformatf("v%0d_enable_calc", i), int'(enable_calc), vecs[i].bsy);
    end
    @(negedge clock);
    chk("done_one_cycle", int'(done), 0);
    chk("after_done_busy", int'(busy), 0);

    // Abort mid-WAIT, then a late result must be ignored.
    start_move(12'd1234);
    wait_req(ok);
    repeat (3) @(negedge clock);
    chk("mid_wait_busy", int'(busy), 1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    delta_angle  = 12'd1000;
    dir_shortest = 1'b1;
    calc_updated = 1'b1;
    @(negedge clock);
    calc_updated = 1'b0;
    @(negedge clock);
    chk("late_result_busy", int'(busy), 0);
    chk("late_result_duty", int'(pwm_duty), 0);
    chk("late_result_req", int'(enable_calc), 0);
    chk("late_result_done", int'(done), 0);

    // Start and abort together in IDLE: abort wins.
    target_angle = 12'd99;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", int'(busy), 0);
    chk("start_abort_req", int'(enable_calc), 0);
    chk("start_abort_target", int'(calc_target), 1234);

    // Reset asserted mid-EVAL clears outputs asynchronously.
    start_move(12'd2000);
    do_eval(12'd1000, 1'b1, ok);
    chk("pre_reset_duty", int'(pwm_duty), 4);
    chk("pre_reset_dir", int'(pwm_dir), 1);
    wait_req(ok);
    repeat (6) @(negedge clock);
    delta_angle  = 12'd1000;
    calc_updated = 1'b1;
    @(negedge clock);
    calc_updated = 1'b0;
    chk("eval_busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
